// File: rtl/encoder_seq_ctrl.sv
// Sequencer for one encoder block: gathers input bytes, kicks the encoder,
// waits for it to finish, then drains the output subblock FIFOs.
module encoder_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int LEN_SHORT      = 132,
    parameter int LEN_LONG       = 768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cbl_sel,
    input  logic       in_wr,
    input  logic       computation_done,
    input  logic       sub_empty,
    output logic       data_valid,
    output logic       code_block_length,
    output logic       rdreq_subblock,
    output logic       out_valid,
    output logic [9:0] out_count,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_KICK   = 3'd2,
        S_ENCODE = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // The timer must hold TIMEOUT_CYCLES-1, which can exceed the 10-bit byte counters.
    localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]     LS   = 10'(LEN_SHORT);
    localparam logic [9:0]     LL   = 10'(LEN_LONG);

    state_t        cur_state;
    state_t        nxt_state;
    logic          start_d;
    logic          cbl;
    logic [9:0]    in_cnt;
    logic [9:0]    out_cnt;
    logic [TW-1:0] timer;
    logic          ov;
    logic [9:0]    len;
    logic          start_edge;
    logic          rd;
    logic          timeout_hit;

    assign len         = cbl ? LL : LS;
    assign start_edge  = start & ~start_d;
    assign rd          = (cur_state == S_DRAIN) & ~sub_empty & (out_cnt < len);
    assign timeout_hit = (timer == TMAX);

    assign data_valid        = (cur_state == S_KICK);
    assign rdreq_subblock    = rd;
    assign out_valid         = ov;
    assign out_count         = out_cnt;
    assign code_block_length = cbl;
    assign busy              = (cur_state != S_IDLE);
    assign done              = (cur_state == S_DONE);
    assign err_timeout       = (cur_state == S_ERR);
    assign state             = cur_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state decision; encoder completion wins over a coincident timeout.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   if (start_edge) nxt_state = S_FILL;
            S_FILL:   if (in_wr && ((in_cnt + 10'd1) == len)) nxt_state = S_KICK;
            S_KICK:   nxt_state = S_ENCODE;
            S_ENCODE: begin
                if (computation_done) begin
                    nxt_state = S_DRAIN;
                end else if (timeout_hit) begin
                    nxt_state = S_ERR;
                end
            end
            S_DRAIN: begin
                if (ov && (out_cnt == len)) begin
                    nxt_state = S_DONE;
                end else if (!rd && timeout_hit) begin
                    nxt_state = S_ERR;
                end
            end
            S_DONE:   nxt_state = S_IDLE;
            S_ERR:    nxt_state = S_ERR;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // Counters, timer, length latch and the one-cycle read-data delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_d <= 1'b0;
            cbl     <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            timer   <= '0;
            ov      <= 1'b0;
        end else begin
            start_d <= start;
            ov      <= rd;
            case (cur_state)
                S_IDLE: begin
                    if (start_edge) begin
                        cbl     <= cbl_sel;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        timer   <= '0;
                    end
                end
                S_FILL: begin
                    if (in_wr) in_cnt <= in_cnt + 10'd1;
                end
                S_KICK: begin
                    timer <= '0;
                end
                S_ENCODE: begin
                    if (computation_done) begin
                        timer <= '0;
                    end else if (!timeout_hit) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (rd) begin
                        out_cnt <= out_cnt + 10'd1;
                        timer   <= '0;
                    end else if (!timeout_hit) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_seq_ctrl.sv
// Directed/randomized bench for encoder_seq_ctrl with a block-level expectation model.
module tb_encoder_seq_ctrl;

    localparam int TO = 64;
    localparam int LS = 132;
    localparam int LL = 768;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cbl_sel = 1'b0;
    logic       in_wr = 1'b0;
    logic       computation_done = 1'b0;
    logic       sub_empty = 1'b1;
    logic       data_valid;
    logic       code_block_length;
    logic       rdreq_subblock;
    logic       out_valid;
    logic [9:0] out_count;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [2:0] state;

    int tests = 0;
    int failed = 0;

    encoder_seq_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .LEN_SHORT(LS),
        .LEN_LONG(LL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cbl_sel(cbl_sel),
        .in_wr(in_wr),
        .computation_done(computation_done),
        .sub_empty(sub_empty),
        .data_valid(data_valid),
        .code_block_length(code_block_length),
        .rdreq_subblock(rdreq_subblock),
        .out_valid(out_valid),
        .out_count(out_count),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_dv"}, 32'(data_valid), 0);
        chk({tag, "_rd"}, 32'(rdreq_subblock), 0);
        chk({tag, "_ov"}, 32'(out_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
        chk({tag, "_cbl"}, 32'(code_block_length), 0);
        chk({tag, "_cnt"}, 32'(out_count), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_wr = 1'b0; computation_done = 1'b0; sub_empty = 1'b1;
        tick();
        tick();
        chk_idle_vals("reset");
        reset = 1'b0;
    endtask

    // enc_wait < 0 means the encoder never finishes; empty_mode 0=never empty,
    // 1=toggle, 2=random; abort_at > 0 resets the block when that many bytes were read.
    task automatic applyStimulus(input bit cbl, input int enc_wait, input int empty_mode,
                                 input bit disturb, input int abort_at);
        int  len;
        int  reads;
        int  n;
        bit  prev;
        bit  exp_rd;
        len = cbl ? LL : LS;

        if (disturb) begin
            for (int k = 0; k < 3; k++) begin
                in_wr = 1'b1;
                #1;
                chk("idle_inwr_state", 32'(state), 0);
                tick();
            end
            in_wr = 1'b0;
        end

        start = 1'b1; cbl_sel = cbl;
        #1;
        chk("pre_start_state", 32'(state), 0);
        tick();
        chk("fill_state", 32'(state), 1);
        chk("fill_busy", 32'(busy), 1);
        chk("fill_cbl", 32'(code_block_length), 32'(cbl));
        chk("fill_cnt_clr", 32'(out_count), 0);

        for (int i = 0; i < len; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_wr = 1'b0;
                if (disturb) begin
                    start = 1'($urandom_range(0, 1));
                    cbl_sel = ~cbl;
                    computation_done = 1'($urandom_range(0, 1));
                end
                #1;
                chk("fill_gap_state", 32'(state), 1);
                tick();
            end
            in_wr = 1'b1;
            if (!disturb) start = 1'b0;
            #1;
            chk("fill_strobe_state", 32'(state), 1);
            chk("fill_dv", 32'(data_valid), 0);
            tick();
        end
        in_wr = 1'b0; start = 1'b0; computation_done = 1'b0; cbl_sel = 1'b0;
        #1;
        chk("kick_state", 32'(state), 2);
        chk("kick_dv", 32'(data_valid), 1);
        chk("kick_rd", 32'(rdreq_subblock), 0);
        chk("kick_cbl_held", 32'(code_block_length), 32'(cbl));
        tick();
        chk("enc_dv_low", 32'(data_valid), 0);

        if (enc_wait < 0) begin
            for (int k = 0; k < TO; k++) begin
                #1;
                chk("enc_wait_state", 32'(state), 3);
                tick();
            end
            chk("to_state", 32'(state), 6);
            chk("to_err", 32'(err_timeout), 1);
            chk("to_dv", 32'(data_valid), 0);
            chk("to_rd", 32'(rdreq_subblock), 0);
            sub_empty = 1'b0;
            tick();
            start = 1'b1;
            tick();
            tick();
            chk("to_restart_state", 32'(state), 6);
            chk("to_err_held", 32'(err_timeout), 1);
            chk("to_rd_held", 32'(rdreq_subblock), 0);
            start = 1'b0;
            return;
        end

        for (int k = 0; k < enc_wait; k++) begin
            #1;
            chk("enc_state", 32'(state), 3);
            tick();
        end
        computation_done = 1'b1;
        #1;
        chk("enc_done_state", 32'(state), 3);
        tick();
        computation_done = 1'b0;

        reads = 0; prev = 1'b0; n = 0;
        while (!(reads == len && prev) && n < len * 4 + 20) begin
            if (abort_at > 0 && reads == abort_at) begin
                chk("abort_cnt", 32'(out_count), 32'(abort_at));
                reset = 1'b1; start = 1'b1; sub_empty = 1'b0;
                tick();
                chk_idle_vals("abort");
                reset = 1'b0;
                tick();
                chk("post_reset_start_state", 32'(state), 1);
                chk("post_reset_busy", 32'(busy), 1);
                start = 1'b0;
                return;
            end
            case (empty_mode)
                0: sub_empty = 1'b0;
                1: sub_empty = 1'(n % 2);
                default: sub_empty = ($urandom_range(0, 3) == 0);
            endcase
            #1;
            exp_rd = !sub_empty && (reads < len);
            chk("drain_state", 32'(state), 4);
            chk("drain_rd", 32'(rdreq_subblock), 32'(exp_rd));
            chk("drain_ov", 32'(out_valid), 32'(prev));
            chk("drain_cnt", 32'(out_count), 32'(reads));
            chk("drain_dv", 32'(data_valid), 0);
            chk("drain_done", 32'(done), 0);
            prev = exp_rd;
            reads += exp_rd ? 1 : 0;
            n++;
            tick();
        end
        chk("drain_budget", 32'(reads == len && prev), 1);
        sub_empty = 1'b0;
        #1;
        chk("last_ov", 32'(out_valid), 1);
        chk("last_state", 32'(state), 4);
        chk("last_rd", 32'(rdreq_subblock), 0);
        tick();
        checkOutput(len);
        sub_empty = 1'b1;
    endtask

    task automatic checkOutput(input int len);
        chk("done_state", 32'(state), 5);
        chk("done_pulse", 32'(done), 1);
        chk("done_cnt", 32'(out_count), 32'(len));
        chk("done_rd", 32'(rdreq_subblock), 0);
        tick();
        chk("end_state", 32'(state), 0);
        chk("end_done", 32'(done), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_cnt_held", 32'(out_count), 32'(len));
        tick();
    endtask

    initial begin
        do_reset();
        applyStimulus(1'b0, 50, 0, 1'b0, 0);
        applyStimulus(1'b1, $urandom_range(1, 60), 1, 1'b0, 0);
        applyStimulus(1'b0, $urandom_range(1, 60), 2, 1'b1, 0);
        applyStimulus(1'b1, TO - 1, 2, 1'b0, 0);
        applyStimulus(1'b0, -1, 0, 1'b0, 0);
        do_reset();
        applyStimulus(1'b0, 20, 0, 1'b0, 40);
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
